brightness_ramp_mpc: RTL and testbench

BRIGHTNESS_RAMP_MPC -- requirements
Module: brightness_ramp_mpc

---
 rtl/brightness_pkg.sv | 13 +
 rtl/brightness_scale_ch.sv | 48 ++++
 rtl/brightness_ramp_mpc.sv | 99 +++++++++
 tb/tb_brightness_ramp_mpc.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/brightness_pkg.sv
// Brightness ramp shared constants and FSM state type.
// Gain is percent * 655, i.e. roughly percent/100 in Q1.16.
package brightness_pkg;
  localparam int BRT_MAX = 100;
  localparam int GAIN_K  = 655;
  localparam int GAIN_W  = 17;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_UP   = 2'd1,
    ST_DOWN = 2'd2
  } state_e;
endpackage

// File: rtl/brightness_scale_ch.sv
// One channel: stage 1 multiply by gain, stage 2 round/saturate/bypass.
// Ports: clk, rst, din[DW], gain[GAIN_W], bypass -> dout[DW] (2 clk).
module brightness_scale_ch
  import brightness_pkg::*;
#(
  parameter int DW = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DW-1:0]     din,
  input  logic [GAIN_W-1:0] gain,
  input  logic              bypass,
  output logic [DW-1:0]     dout
);

  localparam int PW = DW + GAIN_W;

  logic [DW-1:0] d_q, d_d;
  logic [DW+1:0] p_q, p_d;
  logic [DW-1:0] dout_q, dout_d;
  logic [PW-1:0] prod;
  logic [DW:0]   r;

  always_comb begin
    prod   = PW'(din) * PW'(gain);
    d_d    = din;
    // keep one extra LSB for round-half-up in stage 2
    p_d    = (DW+2)'(prod >> 15);
    r      = {1'b0, p_q[DW+1:1]} + (DW+1)'(p_q[0]);
    dout_d = r[DW] ? '1 : r[DW-1:0];
    if (bypass) dout_d = d_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      d_q    <= '0;
      p_q    <= '0;
      dout_q <= '0;
    end else begin
      d_q    <= d_d;
      p_q    <= p_d;
      dout_q <= dout_d;
    end
  end

  assign dout = dout_q;

endmodule

// File: rtl/brightness_ramp_mpc.sv
// Brightness ramp FSM + shared gain scaling NCH channels, 2 clk latency.
// Ports: din/din_vld in, brightness/ovp/ramp_en/ramp_step ctl, dout/dout_vld/busy out.
module brightness_ramp_mpc
  import brightness_pkg::*;
#(
  parameter int DW  = 16,
  parameter int NCH = 3,
  parameter int SW  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NCH*DW-1:0] din,
  input  logic              din_vld,
  input  logic [6:0]        brightness,
  input  logic              ovp,
  input  logic              ramp_en,
  input  logic [SW-1:0]     ramp_step,
  output logic [NCH*DW-1:0] dout,
  output logic              dout_vld,
  output logic              busy
);

  localparam int XW = (SW > 7) ? SW : 7;

  logic [6:0]        tgt_q, tgt_d;
  logic [6:0]        cur_q, cur_d;
  state_e            state_q, state_d;
  logic [GAIN_W-1:0] gain_q, gain_d;
  logic              byp_q, byp_d;
  logic [1:0]        vld_q, vld_d;
  logic [6:0]        nt;
  logic [XW-1:0]     step_x, gap_x;

  always_comb begin
    tgt_d   = tgt_q;
    cur_d   = cur_q;
    state_d = state_q;
    nt      = tgt_q;
    gap_x   = '0;
    step_x  = (ramp_step == '0) ? XW'(1) : XW'(ramp_step);
    if (ovp) begin
      nt    = (brightness > 7'(BRT_MAX)) ? 7'(BRT_MAX) : brightness;
      tgt_d = nt;
      if (!ramp_en) begin
        cur_d = nt;
      end else if (cur_q < nt) begin
        gap_x = XW'(nt - cur_q);
        cur_d = (gap_x <= step_x) ? nt : cur_q + 7'(step_x);
      end else if (cur_q > nt) begin
        gap_x = XW'(cur_q - nt);
        cur_d = (gap_x <= step_x) ? nt : cur_q - 7'(step_x);
      end
      unique case (1'b1)
        (cur_d == nt): state_d = ST_IDLE;
        (cur_d < nt):  state_d = ST_UP;
        default:       state_d = ST_DOWN;
      endcase
    end
    // gain follows cur one cycle later
    gain_d = GAIN_W'(cur_q) * GAIN_W'(GAIN_K);
    byp_d  = (cur_q == 7'(BRT_MAX));
    vld_d  = {vld_q[0], din_vld};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tgt_q   <= '0;
      cur_q   <= '0;
      state_q <= ST_IDLE;
      gain_q  <= '0;
      byp_q   <= 1'b0;
      vld_q   <= '0;
    end else begin
      tgt_q   <= tgt_d;
      cur_q   <= cur_d;
      state_q <= state_d;
      gain_q  <= gain_d;
      byp_q   <= byp_d;
      vld_q   <= vld_d;
    end
  end

  assign busy     = (state_q != ST_IDLE);
  assign dout_vld = vld_q[1];

  for (genvar k = 0; k < NCH; k++) begin : g_ch
    brightness_scale_ch #(
      .DW(DW)
    ) u_ch (
      .clk   (clk),
      .rst   (rst),
      .din   (din[k*DW +: DW]),
      .gain  (gain_q),
      .bypass(byp_q),
      .dout  (dout[k*DW +: DW])
    );
  end

endmodule

// File: tb/tb_brightness_ramp_mpc.sv
// Randomized self-checking bench for brightness_ramp_mpc.
// Two instances: default (DW=16,NCH=3) and DW=12,NCH=4.
module tb_brightness_ramp_mpc;
  import brightness_pkg::*;

  logic        clk = 1'b0;
  logic        rst, din_vld, ovp, ramp_en;
  logic [6:0]  brightness;
  logic [3:0]  ramp_step;
  logic [47:0] din_a, dout_a, din_b, dout_b;
  logic        vld_a, vld_b, busy_a, busy_b;

  int n_cmp = 0;
  int n_bad = 0;
  int m_cur = 0;
  int m_tgt = 0;
  logic [47:0] qa[$];
  logic [47:0] qb[$];
  logic        qv[$];

  always #5 clk = ~clk;

  brightness_ramp_mpc u_a (
    .clk(clk), .rst(rst), .din(din_a), .din_vld(din_vld),
    .brightness(brightness), .ovp(ovp), .ramp_en(ramp_en),
    .ramp_step(ramp_step), .dout(dout_a), .dout_vld(vld_a),
    .busy(busy_a)
  );

  brightness_ramp_mpc #(.DW(12), .NCH(4), .SW(4)) u_b (
    .clk(clk), .rst(rst), .din(din_b), .din_vld(din_vld),
    .brightness(brightness), .ovp(ovp), .ramp_en(ramp_en),
    .ramp_step(ramp_step), .dout(dout_b), .dout_vld(vld_b),
    .busy(busy_b)
  );

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // brightness c percent applied to every channel
  function automatic logic [63:0] ref_bus(input logic [63:0] d,
      input int dw, input int nch, input int c);
    longint unsigned mask, x, p, r, y;
    logic [63:0] o;
    o = '0;
    mask = (64'd1 << dw) - 1;
    for (int k = 0; k < nch; k++) begin
      x = (d >> (k * dw)) & mask;
      if (c == 100) begin
        y = x;
      end else begin
        p = (x * longint'(c) * 655) / 32768;
        r = (p + 1) / 2;
        y = (r > mask) ? mask : r;
      end
      o = o | (y << (k * dw));
    end
    return o;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_cycle(input logic [47:0] da, input logic [47:0] db,
                            input logic v);
    din_a = da;
    din_b = db;
    din_vld = v;
    qa.push_back(ref_bus(64'(da), 16, 3, m_cur));
    qb.push_back(ref_bus(64'(db), 12, 4, m_cur));
    qv.push_back(v);
    tick();
    if (qa.size() == 2) begin
      chk("dout_a", dout_a, qa.pop_front());
      chk("dout_b", dout_b, qb.pop_front());
      chk("vld_a", vld_a, qv[0]);
      chk("vld_b", vld_b, qv.pop_front());
    end
  endtask

  task automatic data_burst(input int n);
    for (int i = 0; i < n; i++)
      push_cycle(48'({$urandom(), $urandom()}),
                 48'({$urandom(), $urandom()}),
                 1'($urandom_range(0, 1)));
  endtask

  task automatic do_ovp(input int b, input bit en, input int st);
    int s;
    brightness = 7'(b);
    ramp_en = en;
    ramp_step = 4'(st);
    ovp = 1'b1;
    tick();
    ovp = 1'b0;
    m_tgt = (b > 100) ? 100 : b;
    s = (st == 0) ? 1 : st;
    if (!en) m_cur = m_tgt;
    else if (m_cur < m_tgt) m_cur = (m_tgt - m_cur <= s) ? m_tgt : m_cur + s;
    else if (m_cur > m_tgt) m_cur = (m_cur - m_tgt <= s) ? m_tgt : m_cur - s;
    chk("cur", u_a.cur_q, 64'(m_cur));
    chk("tgt", u_a.tgt_q, 64'(m_tgt));
    chk("cur_b", u_b.cur_q, 64'(m_cur));
    chk("busy_a", busy_a, 64'(m_cur != m_tgt));
    chk("busy_b", busy_b, 64'(m_cur != m_tgt));
    chk("state", u_a.state_q,
        (m_cur == m_tgt) ? 64'(ST_IDLE) :
        (m_cur < m_tgt) ? 64'(ST_UP) : 64'(ST_DOWN));
    din_vld = 1'b0;
    repeat (3) tick();
    qa.delete();
    qb.delete();
    qv.delete();
  endtask

  initial begin
    rst = 1'b1;
    din_vld = 1'b1;
    ovp = 1'b0;
    ramp_en = 1'b0;
    ramp_step = '0;
    brightness = '0;
    din_a = 48'hFFFF_FFFF_FFFF;
    din_b = 48'hFFF_FFF_FFF_FFF;
    repeat (3) tick();
    chk("rst_dout_a", dout_a, 0);
    chk("rst_dout_b", dout_b, 0);
    chk("rst_vld", vld_a, 0);
    chk("rst_busy", busy_a, 0);
    chk("rst_cur", u_a.cur_q, 0);
    chk("rst_state", u_a.state_q, 64'(ST_IDLE));
    rst = 1'b0;
    din_vld = 1'b0;
    tick();
    data_burst(6);

    // jump to 50%
    do_ovp(50, 0, 0);
    push_cycle(48'h0000_0000_8000, 48'h800_800_800_800, 1'b1);
    push_cycle(48'hFFFF_FFFF_FFFF, 48'hFFF_FFF_FFF_FFF, 1'b1);
    chk("jump50_8000", dout_a[15:0], 16'h3FF7);
    push_cycle(48'h0, 48'h0, 1'b0);
    data_burst(10);

    // bypass at 100%, and clamp of 127
    do_ovp(100, 0, 0);
    repeat (3) push_cycle(48'h1234_1234_1234, 48'h234_234_234_234, 1'b1);
    chk("bypass_a", dout_a, 48'h1234_1234_1234);
    chk("bypass_b", dout_b, 48'h234_234_234_234);
    do_ovp(127, 0, 0);
    chk("clamp_tgt", u_a.tgt_q, 100);
    data_burst(8);

    // ramp 0 -> 100 by 10
    do_ovp(0, 0, 0);
    for (int i = 1; i <= 10; i++) do_ovp(100, 1, 10);
    chk("ramp_end_cur", u_a.cur_q, 100);
    data_burst(6);

    // no overshoot, and step 0 acts as 1
    do_ovp(95, 0, 0);
    do_ovp(100, 1, 10);
    do_ovp(0, 0, 0);
    for (int i = 0; i < 3; i++) do_ovp(3, 1, 0);
    chk("step0_cur", u_a.cur_q, 3);
    data_burst(6);

    // mid-ramp redirect
    do_ovp(0, 0, 0);
    for (int i = 0; i < 4; i++) do_ovp(100, 1, 10);
    do_ovp(20, 1, 10);
    chk("redirect_cur", u_a.cur_q, 30);
    chk("redirect_st", u_a.state_q, 64'(ST_DOWN));
    data_burst(6);

    // reset mid-ramp
    do_ovp(0, 0, 0);
    for (int i = 0; i < 3; i++) do_ovp(90, 1, 7);
    rst = 1'b1;
    din_vld = 1'b1;
    tick();
    chk("mrst_dout_a", dout_a, 0);
    chk("mrst_dout_b", dout_b, 0);
    chk("mrst_vld", vld_b, 0);
    chk("mrst_busy", busy_a, 0);
    chk("mrst_cur", u_a.cur_q, 0);
    chk("mrst_gain", u_a.gain_q, 0);
    // reset beats ovp
    ovp = 1'b1;
    brightness = 7'd80;
    ramp_en = 1'b0;
    tick();
    chk("rst_ovp_cur", u_a.cur_q, 0);
    chk("rst_ovp_tgt", u_a.tgt_q, 0);
    ovp = 1'b0;
    rst = 1'b0;
    din_vld = 1'b0;
    m_cur = 0;
    m_tgt = 0;
    tick();
    do_ovp(30, 1, 5);
    chk("restart_cur", u_a.cur_q, 5);
    data_burst(6);

    // random control and data
    for (int i = 0; i < 40; i++) begin
      do_ovp(int'($urandom_range(0, 127)), 1'($urandom_range(0, 1)),
             int'($urandom_range(0, 15)));
      data_burst(8);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
